// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: drives one imem request at a time and holds the
// fetched word for decode; computes the load value for an external pc register.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        trap
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    FLUSH = 3'd4
  } state_t;

  state_t      state_reg;
  logic        imem_req_reg;
  logic        instr_valid_reg;
  logic [31:0] instr_reg;
  logic [31:0] instr_pc_reg;
  logic        redirect_evt;
  logic [31:0] pc_sel;

  // Redirects are meaningless before the first request has been issued.
  assign redirect_evt = !reset && (state_reg != IDLE) && (trap || redirect_valid);

  always_comb begin
    pc_sel = pc;
    if (reset) begin
      pc_sel = RESET_PC;
    end else if (redirect_evt) begin
      pc_sel = trap ? TRAP_VEC : redirect_pc;
    end else if ((state_reg == HOLD) && instr_ready) begin
      pc_sel = pc + 32'd4;
    end
  end

  assign next_pc     = {pc_sel[31:2], 2'b00};
  assign imem_addr   = pc;
  assign imem_req    = imem_req_reg && !reset;
  assign instr_valid = instr_valid_reg && !reset;
  assign instr       = reset ? 32'd0 : instr_reg;
  assign instr_pc    = reset ? 32'd0 : instr_pc_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      imem_req_reg    <= 1'b0;
      instr_valid_reg <= 1'b0;
      instr_reg       <= 32'd0;
      instr_pc_reg    <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_reg    <= REQ;
          imem_req_reg <= 1'b1;
        end
        REQ: begin
          if (imem_gnt) begin
            state_reg    <= redirect_evt ? FLUSH : WAIT;
            imem_req_reg <= 1'b0;
          end
        end
        WAIT: begin
          // A response that coincides with a redirect belongs to the old path.
          if (imem_rvalid) begin
            state_reg       <= redirect_evt ? REQ : HOLD;
            imem_req_reg    <= redirect_evt;
            instr_valid_reg <= !redirect_evt;
            if (!redirect_evt) begin
              instr_reg    <= imem_rdata;
              instr_pc_reg <= pc;
            end
          end else if (redirect_evt) begin
            state_reg <= FLUSH;
          end
        end
        HOLD: begin
          if (redirect_evt || instr_ready) begin
            state_reg       <= REQ;
            imem_req_reg    <= 1'b1;
            instr_valid_reg <= 1'b0;
          end
        end
        FLUSH: begin
          if (imem_rvalid) begin
            state_reg    <= REQ;
            imem_req_reg <= 1'b1;
          end
        end
        default: begin
          state_reg       <= IDLE;
          imem_req_reg    <= 1'b0;
          instr_valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus a randomized run against a
// transaction-level model (outstanding / live / holding) of the fetch stream.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_ctrl #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
    .clk(clk), .reset(reset), .pc(pc), .next_pc(next_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .trap(trap)
  );

  always #5 clk = ~clk;

  // External pc register loads next_pc on every edge.
  always @(posedge clk) pc <= next_pc;

  // Memory environment
  logic [31:0] mem_tab [logic [31:0]];
  bit          mp;
  int          mcnt;
  logic [31:0] maddr;
  int          gnt_pct;
  int          lat_min;
  int          lat_max;

  // Reference model state
  int          since_rst;
  bit          m_out, m_live, m_hold;
  logic [31:0] m_word, m_pc;
  bit          ev, e_req, e_valid;
  logic [31:0] e_next;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_tab.exists(a)) return mem_tab[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic drive_mem();
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (mp) begin
      if (mcnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_rd(maddr);
        mp = 1'b0;
      end else begin
        mcnt--;
      end
    end
    imem_gnt = imem_req && (int'($urandom_range(99)) < gnt_pct);
  endtask

  // Drive memory, wait for outputs to settle, compute expectations from the rules.
  task automatic settle();
    logic [31:0] t;
    drive_mem();
    @(negedge clk);
    ev = !reset && (since_rst != 0) && (trap || redirect_valid);
    if (reset)                      t = RESET_PC;
    else if (ev)                    t = trap ? TRAP_VEC : redirect_pc;
    else if (m_hold && instr_ready) t = pc + 32'd4;
    else                            t = pc;
    e_next  = {t[31:2], 2'b00};
    e_req   = !reset && (since_rst != 0) && !m_out && !m_hold;
    e_valid = !reset && m_hold;
  endtask

  task automatic advance();
    bit granted;
    granted = imem_req && imem_gnt;
    if (reset) begin
      since_rst = 0;
      m_out = 1'b0;
      m_hold = 1'b0;
    end else begin
      if (since_rst != 0) begin
        if (m_hold) begin
          if (ev || instr_ready) m_hold = 1'b0;
        end else if (m_out) begin
          if (imem_rvalid) begin
            m_out = 1'b0;
            if (m_live && !ev) begin
              m_hold = 1'b1;
              m_word = imem_rdata;
              m_pc   = pc;
            end
          end else if (ev) begin
            m_live = 1'b0;
          end
        end else if (imem_gnt) begin
          m_out  = 1'b1;
          m_live = !ev;
        end
      end
      if (since_rst < 1000000) since_rst++;
    end
    if (granted) begin
      mp    = 1'b1;
      mcnt  = int'($urandom_range(lat_max, lat_min)) - 1;
      maddr = imem_addr;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; trap = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    instr_ready = 1'b0; mp = 1'b0;
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    repeat (n) begin settle(); advance(); end
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; trap = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    instr_ready = 1'b0; mp = 1'b0; gnt_pct = 100; lat_min = 1; lat_max = 1;
    settle(); advance();
    trap = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
    settle();
    n_cmp++; if (next_pc !== RESET_PC) begin n_bad++; $display("FAIL reset_next_pc: got %h expected %h", next_pc, RESET_PC); end
    n_cmp++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_outputs: req=%b valid=%b expected 0/0", imem_req, instr_valid); end
    n_cmp++; if (instr !== 32'd0 || instr_pc !== 32'd0) begin n_bad++; $display("FAIL reset_instr: instr=%h instr_pc=%h expected 0/0", instr, instr_pc); end
    advance();
    reset = 1'b0; trap = 1'b0;
    settle();
    n_cmp++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL idle_outputs: req=%b valid=%b expected 0/0", imem_req, instr_valid); end
    n_cmp++; if (next_pc !== RESET_PC) begin n_bad++; $display("FAIL idle_ignores_redirect: next_pc=%h expected %h", next_pc, RESET_PC); end
    advance();
    redirect_valid = 1'b0;
    settle();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin n_bad++; $display("FAIL first_req: req=%b addr=%h expected 1/%h", imem_req, imem_addr, RESET_PC); end
    advance();
    $display("test_reset done");
  endtask

  task automatic test_sequential();
    logic [31:0] exp_i [3];
    logic [31:0] got_i [$];
    logic [31:0] got_p [$];
    int          got_c [$];
    exp_i = '{32'h11, 32'h22, 32'h33};
    mem_tab[32'h0] = 32'h11; mem_tab[32'h4] = 32'h22; mem_tab[32'h8] = 32'h33;
    do_reset(2);
    instr_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      settle();
      if (instr_valid) begin
        got_i.push_back(instr); got_p.push_back(instr_pc); got_c.push_back(c);
        $display("seq: cycle %0d instr=%h instr_pc=%h", c, instr, instr_pc);
      end
      advance();
    end
    n_cmp++; if (got_i.size() != 3) begin n_bad++; $display("FAIL seq_count: got %0d instrs expected 3", got_i.size()); end
    n_cmp++; if (got_c.size() > 0 && got_c[0] != 3) begin n_bad++; $display("FAIL seq_first_latency: cycle %0d expected 3", got_c[0]); end
    for (int k = 0; k < 3 && k < got_i.size(); k++) begin
      n_cmp++;
      if (got_i[k] !== exp_i[k] || got_p[k] !== 32'(4 * k)) begin
        n_bad++; $display("FAIL seq_pair%0d: got (%h,%h) expected (%h,%h)", k, got_i[k], got_p[k], exp_i[k], 32'(4 * k));
      end
      if (k > 0) begin
        n_cmp++; if (got_c[k] - got_c[k-1] != 3) begin n_bad++; $display("FAIL seq_gap%0d: got %0d expected 3", k, got_c[k] - got_c[k-1]); end
      end
    end
    mem_tab.delete();
  endtask

  task automatic test_backpressure();
    int k;
    do_reset(2);
    for (k = 0; k < 20; k++) begin settle(); if (instr_valid) break; advance(); end
    n_cmp++; if (k == 20) begin n_bad++; $display("FAIL bp_timeout: no instr_valid within 20 cycles"); end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) settle();
      n_cmp++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin n_bad++; $display("FAIL bp_valid%0d: valid=%b req=%b expected 1/0", i, instr_valid, imem_req); end
      n_cmp++; if (instr !== mem_rd(RESET_PC) || instr_pc !== RESET_PC) begin n_bad++; $display("FAIL bp_instr%0d: got (%h,%h) expected (%h,%h)", i, instr, instr_pc, mem_rd(RESET_PC), RESET_PC); end
      n_cmp++; if (pc !== RESET_PC || next_pc !== RESET_PC) begin n_bad++; $display("FAIL bp_pc%0d: pc=%h next_pc=%h expected %h", i, pc, next_pc, RESET_PC); end
      advance();
    end
    instr_ready = 1'b1;
    settle();
    n_cmp++; if (instr_valid !== 1'b1 || next_pc !== RESET_PC + 32'd4) begin n_bad++; $display("FAIL bp_accept: valid=%b next_pc=%h expected 1/%h", instr_valid, next_pc, RESET_PC + 32'd4); end
    $display("bp: accepted instr=%h instr_pc=%h", instr, instr_pc);
    advance();
    instr_ready = 1'b0;
    settle();
    n_cmp++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RESET_PC + 32'd4) begin n_bad++; $display("FAIL bp_next_req: valid=%b req=%b addr=%h expected 0/1/%h", instr_valid, imem_req, imem_addr, RESET_PC + 32'd4); end
    advance();
  endtask

  task automatic test_redirect_wait();
    int  k;
    bit  saw_valid;
    mem_tab[32'h8] = 32'h0000_DEAD;
    do_reset(2);
    instr_ready = 1'b1;
    for (k = 0; k < 20; k++) begin settle(); if (imem_req && imem_addr == 32'h8) break; advance(); end
    n_cmp++; if (k == 20) begin n_bad++; $display("FAIL rw_reach8: no request at 0x8 within 20 cycles"); end
    lat_min = 3; lat_max = 3;
    advance();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    settle();
    n_cmp++; if (imem_req !== 1'b0 || next_pc !== 32'h40) begin n_bad++; $display("FAIL rw_event: req=%b next_pc=%h expected 0/00000040", imem_req, next_pc); end
    advance();
    redirect_valid = 1'b0; lat_min = 1; lat_max = 1;
    saw_valid = 1'b0;
    for (k = 0; k < 10; k++) begin
      settle();
      if (instr_valid) saw_valid = 1'b1;
      if (imem_req) break;
      advance();
    end
    n_cmp++; if (saw_valid) begin n_bad++; $display("FAIL rw_stale_presented: instr_valid=1 expected 0 before refetch"); end
    n_cmp++; if (k == 10 || imem_addr !== 32'h40) begin n_bad++; $display("FAIL rw_next_addr: addr=%h expected 00000040", imem_addr); end
    advance();
    for (k = 0; k < 10; k++) begin settle(); if (instr_valid) break; advance(); end
    n_cmp++; if (k == 10 || instr_pc !== 32'h40 || instr !== mem_rd(32'h40)) begin n_bad++; $display("FAIL rw_refetch: got (%h,%h) expected (%h,00000040)", instr, instr_pc, mem_rd(32'h40)); end
    $display("rw: fetched instr=%h instr_pc=%h", instr, instr_pc);
    advance();
    mem_tab.delete();
  endtask

  task automatic test_trap_priority();
    int k;
    do_reset(2);
    for (k = 0; k < 20; k++) begin settle(); if (instr_valid) break; advance(); end
    n_cmp++; if (k == 20) begin n_bad++; $display("FAIL tp_timeout: no instr_valid within 20 cycles"); end
    advance();
    trap = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80; instr_ready = 1'b1;
    settle();
    n_cmp++; if (next_pc !== TRAP_VEC) begin n_bad++; $display("FAIL tp_next_pc: got %h expected %h", next_pc, TRAP_VEC); end
    advance();
    trap = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
    settle();
    n_cmp++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== TRAP_VEC) begin n_bad++; $display("FAIL tp_dropped: valid=%b req=%b addr=%h expected 0/1/%h", instr_valid, imem_req, imem_addr, TRAP_VEC); end
    advance();
  endtask

  task automatic test_misalign_wrap();
    int k;
    do_reset(2);
    gnt_pct = 0;
    settle(); advance();
    redirect_valid = 1'b1; redirect_pc = 32'h43;
    settle();
    n_cmp++; if (imem_req !== 1'b1 || next_pc !== 32'h40) begin n_bad++; $display("FAIL mw_align: req=%b next_pc=%h expected 1/00000040", imem_req, next_pc); end
    advance();
    redirect_pc = 32'hFFFF_FFFC;
    settle();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_bad++; $display("FAIL mw_addr40: req=%b addr=%h expected 1/00000040", imem_req, imem_addr); end
    advance();
    redirect_valid = 1'b0; gnt_pct = 100; instr_ready = 1'b1;
    settle();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL mw_addr_top: req=%b addr=%h expected 1/fffffffc", imem_req, imem_addr); end
    advance();
    for (k = 0; k < 10; k++) begin settle(); if (instr_valid) break; advance(); end
    n_cmp++; if (k == 10 || instr_pc !== 32'hFFFF_FFFC || next_pc !== 32'h0) begin n_bad++; $display("FAIL mw_wrap: instr_pc=%h next_pc=%h expected fffffffc/00000000", instr_pc, next_pc); end
    advance();
    settle();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_bad++; $display("FAIL mw_wrap_req: req=%b addr=%h expected 1/00000000", imem_req, imem_addr); end
    advance();
  endtask

  task automatic test_reset_flush();
    do_reset(2);
    settle(); advance();
    redirect_valid = 1'b1; redirect_pc = 32'h20; lat_min = 2; lat_max = 2;
    settle();
    n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL rf_req: req=%b expected 1", imem_req); end
    advance();
    redirect_valid = 1'b0; reset = 1'b1;
    settle();
    n_cmp++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || next_pc !== RESET_PC) begin n_bad++; $display("FAIL rf_in_reset: req=%b valid=%b next_pc=%h expected 0/0/%h", imem_req, instr_valid, next_pc, RESET_PC); end
    advance();
    reset = 1'b0; lat_min = 1; lat_max = 1;
    settle();
    n_cmp++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || next_pc !== RESET_PC) begin n_bad++; $display("FAIL rf_idle: req=%b valid=%b next_pc=%h expected 0/0/%h", imem_req, instr_valid, next_pc, RESET_PC); end
    advance();
    settle();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC || instr_valid !== 1'b0) begin n_bad++; $display("FAIL rf_req_after: req=%b addr=%h valid=%b expected 1/%h/0", imem_req, imem_addr, instr_valid, RESET_PC); end
    advance();
  endtask

  task automatic test_random();
    int n_acc = 0;
    do_reset(2);
    gnt_pct = 60; lat_min = 1; lat_max = 3;
    for (int c = 0; c < 1200; c++) begin
      reset = ($urandom_range(199) == 0);
      if (reset) mp = 1'b0;
      instr_ready    = $urandom_range(1) == 1;
      trap           = $urandom_range(99) < 3;
      redirect_valid = $urandom_range(99) < 8;
      redirect_pc    = ($urandom_range(3) == 0) ? $urandom : ($urandom & 32'h0000_0FFF);
      settle();
      n_cmp++; if (next_pc !== e_next) begin n_bad++; $display("FAIL rnd_next_pc c%0d: got %h expected %h", c, next_pc, e_next); end
      n_cmp++; if (imem_req !== e_req) begin n_bad++; $display("FAIL rnd_req c%0d: got %b expected %b", c, imem_req, e_req); end
      n_cmp++; if (instr_valid !== e_valid) begin n_bad++; $display("FAIL rnd_valid c%0d: got %b expected %b", c, instr_valid, e_valid); end
      n_cmp++; if (imem_req && mp) begin n_bad++; $display("FAIL rnd_outstanding c%0d: req=1 with response pending, expected req=0", c); end
      if (e_req) begin
        n_cmp++; if (imem_addr !== pc) begin n_bad++; $display("FAIL rnd_addr c%0d: got %h expected %h", c, imem_addr, pc); end
      end
      if (e_valid) begin
        n_cmp++; if (instr !== m_word || instr_pc !== m_pc) begin n_bad++; $display("FAIL rnd_instr c%0d: got (%h,%h) expected (%h,%h)", c, instr, instr_pc, m_word, m_pc); end
      end
      if (reset) begin
        n_cmp++; if (instr !== 32'd0 || instr_pc !== 32'd0) begin n_bad++; $display("FAIL rnd_reset_instr c%0d: got (%h,%h) expected 0/0", c, instr, instr_pc); end
      end
      if (e_valid && instr_ready && !ev) begin
        n_acc++;
        $display("rnd: accept instr=%h instr_pc=%h", m_word, m_pc);
      end
      advance();
    end
    reset = 1'b0;
    n_cmp++; if (n_acc < 20) begin n_bad++; $display("FAIL rnd_progress: %0d accepted expected at least 20", n_acc); end
  endtask

  initial begin
    since_rst = 0; m_out = 0; m_live = 0; m_hold = 0; m_word = 0; m_pc = 0;
    mp = 0; mcnt = 0; maddr = 0; gnt_pct = 100; lat_min = 1; lat_max = 1;
    reset = 1'b1; trap = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    instr_ready = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    #1;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_trap_priority();
    test_misalign_wrap();
    test_reset_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
